// File: rtl/conv3x3_stream.sv
// Streaming 3x3 convolution: two line buffers, zeroed perimeter, optional clamp (CONV_SATURATE_EN).
// Result(x,y) registers one cycle after pixel y*WIDTH+x+WIDTH+1 is taken; a stalled output drops in_ready.
module conv3x3_stream #(
  parameter int WIDTH     = 200,
  parameter int HEIGHT    = 100,
  parameter int WORD_SIZE = 8,
  parameter int SHIFT     = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [9*WORD_SIZE-1:0] kernel,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WORD_SIZE-1:0]   in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WORD_SIZE-1:0]   out_data,
  output logic                   busy,
  output logic                   done
);
  localparam int ACC = 2*WORD_SIZE+4;
  localparam int XW  = $clog2(WIDTH);
  localparam int YW  = $clog2(HEIGHT+1);
  localparam int CW  = $clog2(WIDTH*HEIGHT+WIDTH+2);
  localparam logic [XW-1:0] XLAST     = XW'(WIDTH-1);
  localparam logic [YW-1:0] YLAST     = YW'(HEIGHT-1);
  localparam logic [CW-1:0] FILL_LAST = CW'(WIDTH);
  localparam logic [CW-1:0] PIX_LAST  = CW'(WIDTH*HEIGHT-1);
  localparam logic [CW-1:0] TOTAL     = CW'(WIDTH*HEIGHT);
  localparam logic signed [ACC-1:0] PMAX = ACC'(2**WORD_SIZE-1);

  typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;
  state_t state, state_nxt;

  logic signed [WORD_SIZE-1:0] kr [9];
  logic [WORD_SIZE-1:0] lb1 [WIDTH];
  logic [WORD_SIZE-1:0] lb2 [WIDTH];
  logic [WORD_SIZE-1:0] col0 [3];
  logic [WORD_SIZE-1:0] col1 [3];
  logic [WORD_SIZE-1:0] col2 [3];
  logic [XW-1:0]        xc, xo;
  logic [YW-1:0]        yo;
  logic [CW-1:0]        in_cnt, out_cnt;
  logic                 step, emit, fin;
  logic [WORD_SIZE-1:0] pix_in, res;
  logic signed [ACC-1:0] acc, acc_sh;

  assign busy   = (state != IDLE);
  assign pix_in = (state == FLUSH) ? '0 : in_data;

  // step: a pixel (real, or zero while flushing) enters the window; emit: a result is loaded
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    step      = 1'b0;
    emit      = 1'b0;
    fin       = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = FILL;
      FILL: begin
        in_ready = 1'b1;
        step     = in_valid;
        if (in_valid && in_cnt == FILL_LAST) state_nxt = RUN;
      end
      RUN: begin
        in_ready = !out_valid || out_ready;
        step     = in_valid && in_ready;
        emit     = step;
        if (step && in_cnt == PIX_LAST) state_nxt = FLUSH;
      end
      FLUSH: begin
        if (out_cnt != TOTAL) begin
          step = !out_valid || out_ready;
          emit = step;
        end else if (out_valid && out_ready) begin
          fin       = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // col0 is the column arriving now (x+1); col1/col2 hold columns x and x-1
  always_comb begin
    col0[0] = pix_in;
    col0[1] = lb1[xc];
    col0[2] = lb2[xc];
    acc = '0;
    for (int j = 0; j < 3; j++) begin
      acc = acc + ACC'(kr[j])   * ACC'(signed'({1'b0, col0[j]}));
      acc = acc + ACC'(kr[3+j]) * ACC'(signed'({1'b0, col1[j]}));
      acc = acc + ACC'(kr[6+j]) * ACC'(signed'({1'b0, col2[j]}));
    end
    acc_sh = acc >>> SHIFT;
`ifdef CONV_SATURATE_EN
    if (acc_sh[ACC-1])      res = '0;
    else if (acc_sh > PMAX) res = '1;
    else                    res = WORD_SIZE'(acc_sh);
`else
    res = WORD_SIZE'(acc_sh);
`endif
    // masking the perimeter also discards every window that straddles a line wrap
    if (xo == '0 || xo == XLAST || yo == '0 || yo == YLAST) res = '0;
  end

  always_ff @(posedge clk) begin
    if (step) begin
      lb1[xc] <= pix_in;
      lb2[xc] <= lb1[xc];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_data  <= '0;
      done      <= 1'b0;
      in_cnt    <= '0;
      out_cnt   <= '0;
      xc        <= '0;
      xo        <= '0;
      yo        <= '0;
      col1      <= '{default: '0};
      col2      <= '{default: '0};
      kr        <= '{default: '0};
    end else begin
      state <= state_nxt;
      done  <= fin;
      if (state == IDLE && start) begin
        for (int q = 0; q < 9; q++) kr[q] <= kernel[q*WORD_SIZE +: WORD_SIZE];
        in_cnt  <= '0;
        out_cnt <= '0;
        xc      <= '0;
        xo      <= '0;
        yo      <= '0;
      end
      if (step) begin
        in_cnt <= in_cnt + CW'(1);
        xc     <= (xc == XLAST) ? '0 : xc + XW'(1);
        col2   <= col1;
        col1   <= col0;
      end
      if (emit) begin
        out_valid <= 1'b1;
        out_data  <= res;
        out_cnt   <= out_cnt + CW'(1);
        if (xo == XLAST) begin
          xo <= '0;
          yo <= yo + YW'(1);
        end else begin
          xo <= xo + XW'(1);
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_conv3x3_stream.sv
// Directed bench for conv3x3_stream on an 8x6 frame: identity, asymmetric, clamp/wrap kernels,
// output stalls, start/kernel changes while busy, and reset mid-frame.
module tb_conv3x3_stream;
  localparam int W  = 8;
  localparam int H  = 6;
  localparam int WS = 8;
  localparam int N  = W*H;

  logic clk = 1'b0;
  logic reset, start, in_valid, in_ready, out_valid, out_ready, busy, done;
  logic [9*WS-1:0] kernel;
  logic [WS-1:0]   in_data, out_data;
  int total = 0;
  int bad   = 0;

  conv3x3_stream #(.WIDTH(W), .HEIGHT(H), .WORD_SIZE(WS), .SHIFT(0)) dut (
    .clk(clk), .reset(reset), .start(start), .kernel(kernel),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // kind 0 identity, 1 all ones, 2 centre -1, 3 k[0][1]=1 k[1][0]=2 k[2][2]=-1
  function automatic logic [9*WS-1:0] kern(input int kind);
    logic [9*WS-1:0] k;
    k = '0;
    case (kind)
      0: k[4*WS +: WS] = 8'd1;
      1: for (int q = 0; q < 9; q++) k[q*WS +: WS] = 8'd1;
      2: k[4*WS +: WS] = 8'hFF;
      default: begin
        k[1*WS +: WS] = 8'd1;
        k[3*WS +: WS] = 8'd2;
        k[8*WS +: WS] = 8'hFF;
      end
    endcase
    return k;
  endfunction

  function automatic logic [WS-1:0] pixv(input int kind, input int idx);
    case (kind)
      1: return 8'd50;
      2: return 8'd7;
      default: return WS'(idx);
    endcase
  endfunction

  function automatic int expv(input int kind, input int m);
    int x, y;
    x = m % W;
    y = m / W;
    if (x == 0 || x == W-1 || y == 0 || y == H-1) return 0;
    case (kind)
      0: return 8*y + x;
`ifdef CONV_SATURATE_EN
      1: return 255;
      2: return 0;
`else
      1: return 194;
      2: return 249;
`endif
      default: return 16*y + 2*x + 26;
    endcase
  endfunction

  task automatic run_frame(input string tag, input int kind, input bit stall, input bit poke, input int abort_at);
    int pix_i = 0, out_i = 0, dones = 0, viol = 0, extra = 0, cyc = 0;
    bit first = 1'b1, held = 1'b0;
    logic [WS-1:0] held_dat = '0;
    kernel = kern(kind);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    chk({tag, "_fill_busy"}, busy, 1);
    chk({tag, "_fill_in_ready"}, in_ready, 1);
    while (out_i < N && cyc < 2000 && !(abort_at >= 0 && pix_i == abort_at)) begin
      in_valid  = (pix_i < N);
      in_data   = pixv(kind, pix_i);
      out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      start     = poke && pix_i == 30;
      if (poke && pix_i == 30) kernel = kern(1);
      #1;
      if (held && !(out_valid && out_data == held_dat)) viol++;
      held     = out_valid && !out_ready;
      held_dat = out_data;
      if (out_valid && !out_ready && in_ready) viol++;
      if (done) dones++;
      if (out_valid && first) begin
        chk({tag, "_latency"}, pix_i, W+2);
        first = 1'b0;
      end
      if (out_valid && out_ready) begin
        chk($sformatf("%s_out%0d", tag, out_i), out_data, expv(kind, out_i));
        out_i++;
      end
      if (in_valid && in_ready) pix_i++;
      cyc++;
      @(negedge clk);
    end
    in_valid  = 1'b0;
    start     = 1'b0;
    out_ready = 1'b1;
    if (abort_at < 0) begin
      for (int t = 0; t < 4; t++) begin
        #1;
        if (done) dones++;
        if (out_valid) extra++;
        @(negedge clk);
      end
      chk({tag, "_count"}, out_i, N);
      chk({tag, "_done_pulses"}, dones, 1);
      chk({tag, "_extra_out"}, extra, 0);
      chk({tag, "_stall_viol"}, viol, 0);
      chk({tag, "_idle_busy"}, busy, 0);
    end else begin
      chk({tag, "_reached"}, pix_i, abort_at);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; kernel = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("idle_in_ready", in_ready, 0);
    chk("idle_busy", busy, 0);

    run_frame("ident", 0, 1'b0, 1'b0, -1);
    run_frame("stall", 0, 1'b1, 1'b0, -1);
    run_frame("ones",  1, 1'b0, 1'b0, -1);
    run_frame("neg",   2, 1'b0, 1'b0, -1);
    run_frame("asym",  3, 1'b0, 1'b0, -1);
    run_frame("poke",  0, 1'b0, 1'b1, -1);

    run_frame("abort", 0, 1'b0, 1'b0, 20);
    chk("abort_pre_valid", out_valid, 1);
    reset = 1'b1;
    #1;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_out_data", out_data, 0);
    chk("abort_in_ready", in_ready, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    @(negedge clk);
    reset = 1'b0;
    run_frame("after", 0, 1'b0, 1'b0, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/conv3x3_stream.md
CONV3X3_STREAM -- requirements
Module: conv3x3_stream

Interface
REQ-001 Parameters SHALL be: WIDTH, 200, pixels per line (>=3); HEIGHT, 100, lines per frame (>=3); WORD_SIZE, 8, pixel and coefficient bits; SHIFT, 0, right-shift applied to the sum before output.
REQ-002 clk  in  1  sole clock, all state on rising edge.
REQ-003 reset  in  1  asynchronous, active-high.
REQ-004 start  in  1  frame start request, honoured only in IDLE.
REQ-005 kernel  in  9*WORD_SIZE  signed coefficients; k[i][j] at bits [(3i+j)*WORD_SIZE +: WORD_SIZE], i = x offset, j = y offset.
REQ-006 in_valid/in_ready/in_data  in/out/in  1/1/WORD_SIZE  raster-order unsigned pixel stream, x fastest.
REQ-007 out_valid/out_ready/out_data  out/in/out  1/1/WORD_SIZE  raster-order result stream.
REQ-008 busy  out  1  high in any state other than IDLE.
REQ-009 done  out  1  single-cycle pulse at frame completion.

Function
REQ-010 States SHALL be IDLE, FILL, RUN, FLUSH; IDLE->FILL on start, at which kernel is latched into internal registers.
REQ-011 FILL SHALL accept the first WIDTH+1 pixels with in_ready=1 and out_valid=0, then go to RUN.
REQ-012 RUN SHALL accept one pixel and emit one result per transfer; in_ready = !out_valid || out_ready; leaves for FLUSH after pixel WIDTH*HEIGHT-1 is accepted.
REQ-013 FLUSH SHALL hold in_ready=0, feed zero pixels internally, and emit the remaining WIDTH+1 results; after the last output handshake, done=1 for one cycle and state returns to IDLE.
REQ-014 Two WIDTH-deep line buffers plus a 3x3 window register SHALL be used; no full-frame storage.
REQ-015 Result(x,y) SHALL be sum over i,j in 0..2 of k[i][j]*p(x+1-i, y+1-j), pixels zero-extended, coefficients sign-extended, accumulated in 2*WORD_SIZE+4 signed bits, then arithmetic-shifted right by SHIFT.
REQ-016 Result(x,y) SHALL be 0 when x==0, x==WIDTH-1, y==0 or y==HEIGHT-1; line wrap SHALL never mix pixels of adjacent rows into a window.
REQ-017 out_data/out_valid SHALL be registered; result(x,y) SHALL appear the cycle after pixel index y*WIDTH+x+WIDTH+1 is accepted (or its FLUSH slot).
REQ-018 out_valid SHALL stay high with out_data stable until out_ready; a stalled output SHALL drop in_ready and lose no data.
REQ-019 Exactly WIDTH*HEIGHT results SHALL be emitted per frame.
REQ-020 start while busy SHALL be ignored; kernel changes while busy SHALL not affect the current frame.

Reset
REQ-021 reset SHALL immediately force state IDLE, out_valid=0, out_data=0, in_ready=0, busy=0, done=0, window and counters zero.
REQ-022 reset mid-frame SHALL abandon the frame; line-buffer contents need not be cleared since FILL overwrites them before use.

Configuration
REQ-023 Macro CONV_SATURATE_EN defined: shifted sum SHALL clamp to [0, 2^WORD_SIZE-1].
REQ-024 Macro CONV_SATURATE_EN undefined: out_data SHALL be the low WORD_SIZE bits of the shifted sum (wrap).

Verification
REQ-025 WIDTH=8, HEIGHT=6, identity kernel (k[1][1]=1, SHIFT=0), p(x,y)=8y+x -> interior out = 8y+x, perimeter 0, 48 outputs, one done pulse.
REQ-026 All-ones kernel, constant pixel 50, WORD_SIZE=8 -> interior 255 with CONV_SATURATE_EN, 194 (450 mod 256) without.
REQ-027 k[1][1]=-1, others 0, pixel 7 -> interior 0 with CONV_SATURATE_EN, 249 without.
REQ-028 out_ready toggled pseudo-randomly during REQ-025 frame -> identical output sequence, in_ready low whenever out_valid && !out_ready.
REQ-029 reset asserted at pixel 20, then new frame started -> outputs 0 immediately after reset, second frame matches REQ-025 exactly.
REQ-030 start pulsed during RUN -> ignored, single done pulse, 48 outputs.
